// File: rtl/serial_pkg.sv
// Shared types and constants for the asynchronous serial receive path.
package serial_pkg;

    // Receiver frame-tracking states, in the order a frame is walked.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Level of the line between frames (and of a good stop bit).
    localparam logic LINE_IDLE = 1'b1;

    // Parity sense: the xor of data and parity bit must equal this value.
    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Parallel valid/ready frame port between the receiver and its consumer.
interface serial_frame_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 parity_error;
    logic                 frame_error;
    logic                 overrun;

    // Receiver side: presents frames and status flags.
    modport master (
        output out_data,
        output out_valid,
        input  out_ready,
        output parity_error,
        output frame_error,
        output overrun
    );

    // Consumer side: observes frames and grants acceptance.
    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready,
        input  parity_error,
        input  frame_error,
        input  overrun
    );
endinterface

// File: rtl/serial_frame_receiver_sync.sv
// Two-flop synchronizer for bringing an asynchronous level into the clock domain.
module sync_two_stage #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops; reset to the line's idle level.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: every clocked assignment is non-blocking so all flops sample pre-edge values together.
        if (reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start detect, mid-bit sampling, parity/stop check, one-deep output slot.
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx_serial,
    output logic                    busy,
    serial_frame_receiver_if.master out_port
);
    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic              PARITY_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
    localparam rx_state_e         AFTER_DATA  = (PARITY_EN != 0) ? PARITY : STOP;

    logic rx_s;

    rx_state_e            state_q;
    logic [TICK_W-1:0]    tick_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_err_q;

    logic [DATA_BITS-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 parity_error_q;
    logic                 frame_error_q;
    logic                 overrun_q;

    logic slot_free;
    logic tick_at_half;
    logic tick_at_last;

    sync_two_stage #(
        .RESET_VALUE (LINE_IDLE)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (rx_serial),
        .q_o   (rx_s)
    );

    // The slot can take a new frame when empty or when its frame leaves this same cycle.
    assign slot_free    = !out_valid_q || out_port.out_ready;
    assign tick_at_half = (tick_q == TICK_HALF);
    assign tick_at_last = (tick_q == TICK_LAST);

    // Frame FSM with bit timing, shift register and registered output slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            tick_q         <= '0;
            idx_q          <= '0;
            shift_q        <= '0;
            parity_err_q   <= 1'b0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (out_valid_q && out_port.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rx_s != LINE_IDLE) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                end

                START: begin
                    if (tick_at_half) begin
                        tick_q  <= '0;
                        idx_q   <= '0;
                        // A line that is high again at mid start bit was only a glitch.
                        state_q <= (rx_s == LINE_IDLE) ? IDLE : DATA;
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                DATA: begin
                    if (tick_at_last) begin
                        tick_q  <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_q <= AFTER_DATA;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                PARITY: begin
                    if (tick_at_last) begin
                        tick_q       <= '0;
                        parity_err_q <= ((^shift_q) ^ rx_s) != PARITY_MODE;
                        state_q      <= STOP;
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                STOP: begin
                    if (tick_at_last) begin
                        tick_q <= '0;
                        if (slot_free) begin
                            out_data_q     <= shift_q;
                            parity_error_q <= parity_err_q;
                            frame_error_q  <= (rx_s != LINE_IDLE);
                            out_valid_q    <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                        // A low stop bit must see the line recover before a new start counts.
                        state_q <= (rx_s == LINE_IDLE) ? IDLE : WAIT_HIGH;
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s == LINE_IDLE) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy                  = (state_q != IDLE);
    assign out_port.out_data     = out_data_q;
    assign out_port.out_valid    = out_valid_q;
    assign out_port.parity_error = parity_error_q;
    assign out_port.frame_error  = frame_error_q;
    assign out_port.overrun      = overrun_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (8 data bits, 16 clocks/bit, even parity).
module tb_serial_frame_receiver;
    logic clock;
    logic reset;
    logic rx_serial;
    logic busy;

    int checks   = 0;
    int failures = 0;

    int          ov_cnt    = 0;
    int          acc_cnt   = 0;
    logic [7:0]  last_acc  = '0;

    int rise;
    int ov_before;
    int acc_before;

    serial_frame_receiver_if #(.DATA_BITS(8)) out_if ();

    serial_frame_receiver #(
        .DATA_BITS    (8),
        .CLKS_PER_BIT (16),
        .PARITY_EN    (1),
        .PARITY_ODD   (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_serial (rx_serial),
        .busy      (busy),
        .out_port  (out_if.master)
    );

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles with the overrun pulse high.
    always @(negedge clock) begin
        if (out_if.overrun === 1'b1) ov_cnt++;
    end

    // Log every frame handed over on the valid/ready port.
    always @(posedge clock) begin
        if (out_if.out_valid === 1'b1 && out_if.out_ready === 1'b1) begin
            acc_cnt++;
            last_acc = out_if.out_data;
        end
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one 11-bit frame from a negedge; optionally pulse out_ready for one cycle at ready_at.
    // rise_cyc returns the negedge index at which out_valid was first seen rising (-1 if not).
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int ready_at, output int rise_cyc);
        logic [10:0] frame;
        logic        was_valid;
        frame     = {stop, par, data, 1'b0};
        was_valid = out_if.out_valid;
        rise_cyc  = -1;
        for (int c = 0; c < 176; c++) begin
            rx_serial = frame[c / 16];
            if (ready_at >= 0) out_if.out_ready = (c == ready_at);
            @(negedge clock);
            if (!was_valid && out_if.out_valid === 1'b1 && rise_cyc < 0) rise_cyc = c + 1;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic accept_one();
        out_if.out_ready = 1'b1;
        @(negedge clock);
        out_if.out_ready = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        rx_serial        = 1'b1;
        out_if.out_ready = 1'b0;
        wait_cycles(3);

        check("rst_valid", out_if.out_valid, 0);
        check("rst_data", out_if.out_data, 0);
        check("rst_perr", out_if.parity_error, 0);
        check("rst_ferr", out_if.frame_error, 0);
        check("rst_ovr", out_if.overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        wait_cycles(4);

        // 1: clean 0xA5 (four ones, even parity bit 0), held until accepted
        send_frame(8'hA5, 1'b0, 1'b1, -1, rise);
        check("t1_latency", rise, 171);
        check("t1_valid", out_if.out_valid, 1);
        check("t1_data", out_if.out_data, 8'hA5);
        check("t1_perr", out_if.parity_error, 0);
        check("t1_ferr", out_if.frame_error, 0);
        check("t1_busy", busy, 0);
        wait_cycles(10);
        check("t1_hold_valid", out_if.out_valid, 1);
        check("t1_hold_data", out_if.out_data, 8'hA5);
        accept_one();
        check("t1_accept_valid", out_if.out_valid, 0);
        check("t1_accept_log", last_acc, 8'hA5);

        // 2: 5-clock low glitch is rejected at mid start bit
        rx_serial = 1'b0;
        wait_cycles(4);
        check("t2_busy_glitch", busy, 1);
        wait_cycles(1);
        rx_serial = 1'b1;
        wait_cycles(20);
        check("t2_busy_idle", busy, 0);
        check("t2_no_valid", out_if.out_valid, 0);
        send_frame(8'h3C, 1'b0, 1'b1, -1, rise);
        check("t2_valid", out_if.out_valid, 1);
        check("t2_data", out_if.out_data, 8'h3C);
        check("t2_perr", out_if.parity_error, 0);
        accept_one();

        // 3: 0x01 has odd weight, so parity bit 0 is wrong for even parity
        send_frame(8'h01, 1'b0, 1'b1, -1, rise);
        check("t3_data", out_if.out_data, 8'h01);
        check("t3_perr", out_if.parity_error, 1);
        check("t3_ferr", out_if.frame_error, 0);
        accept_one();
        check("t3_flags_kept", out_if.parity_error, 1);

        // 4: stop bit 0, then line held low 40 clocks from stop start
        send_frame(8'h3C, 1'b0, 1'b0, -1, rise);
        wait_cycles(24);
        check("t4_valid", out_if.out_valid, 1);
        check("t4_data", out_if.out_data, 8'h3C);
        check("t4_ferr", out_if.frame_error, 1);
        check("t4_perr", out_if.parity_error, 0);
        check("t4_busy_wait_high", busy, 1);
        accept_one();
        rx_serial = 1'b1;
        wait_cycles(5);
        check("t4_busy_idle", busy, 0);
        check("t4_no_new_frame", out_if.out_valid, 0);

        // 5a: back-to-back 0x11, 0x22 with no acceptance -> 0x22 dropped
        ov_before = ov_cnt;
        send_frame(8'h11, 1'b0, 1'b1, -1, rise);
        send_frame(8'h22, 1'b0, 1'b1, -1, rise);
        check("t5a_overrun_cycles", ov_cnt - ov_before, 1);
        check("t5a_data_kept", out_if.out_data, 8'h11);
        check("t5a_valid", out_if.out_valid, 1);

        // 5b: slot still holds 0x11; ready only on the 0x22 stop-sample edge
        ov_before  = ov_cnt;
        acc_before = acc_cnt;
        send_frame(8'h22, 1'b0, 1'b1, 170, rise);
        check("t5b_overrun_none", ov_cnt - ov_before, 0);
        check("t5b_data", out_if.out_data, 8'h22);
        check("t5b_valid", out_if.out_valid, 1);
        check("t5b_accept_cnt", acc_cnt - acc_before, 1);
        check("t5b_accept_log", last_acc, 8'h11);

        // 6: reset three data bits into 0xFF while 0x22 still occupies the slot
        rx_serial = 1'b0;
        wait_cycles(16);
        rx_serial = 1'b1;
        wait_cycles(48);
        check("t6_busy_before", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", out_if.out_valid, 0);
        check("t6_rst_data", out_if.out_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ovr", out_if.overrun, 0);
        @(negedge clock);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(4);
        check("t6_idle_after", busy, 0);
        send_frame(8'h5A, 1'b0, 1'b1, -1, rise);
        check("t6_latency", rise, 171);
        check("t6_data", out_if.out_data, 8'h5A);
        check("t6_valid", out_if.out_valid, 1);
        check("t6_perr", out_if.parity_error, 0);
        check("t6_ferr", out_if.frame_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
